// File: rtl/axis_reduce_endpoint_if.sv
// Flit input and response output bundle for axis_reduce_endpoint.
// The endpoint connects through the slave modport; the traffic source and response consumer use master.
interface axis_reduce_endpoint_if #(
  parameter int DATA_WIDTH = 64,
  parameter int TID_WIDTH  = 2,
  parameter int ACC_WIDTH  = 64,
  parameter int CNT_WIDTH  = 16
);
  logic                  axis_in_tvalid;
  logic                  axis_in_tready;
  logic [DATA_WIDTH-1:0] axis_in_tdata;
  logic                  axis_in_tlast;
  logic [TID_WIDTH-1:0]  axis_in_tid;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [ACC_WIDTH-1:0]  resp_data;
  logic [TID_WIDTH-1:0]  resp_tid;
  logic [CNT_WIDTH-1:0]  resp_count;
  logic                  resp_overflow;

  modport master (
    output axis_in_tvalid, axis_in_tdata, axis_in_tlast, axis_in_tid, resp_ready,
    input  axis_in_tready, resp_valid, resp_data, resp_tid, resp_count, resp_overflow
  );

  modport slave (
    input  axis_in_tvalid, axis_in_tdata, axis_in_tlast, axis_in_tid, resp_ready,
    output axis_in_tready, resp_valid, resp_data, resp_tid, resp_count, resp_overflow
  );
endinterface

// File: rtl/axis_reduce_endpoint.sv
// Multi-stream AXI-Stream reduction endpoint: per-tid accumulators feeding an in-order response FIFO.
// Define AXIS_REDUCE_SAT_EN to make add saturate and report overflow; otherwise add wraps.
module axis_reduce_endpoint #(
  parameter int DATA_WIDTH      = 64,
  parameter int TID_WIDTH       = 2,
  parameter int ACC_WIDTH       = 64,
  parameter int CNT_WIDTH       = 16,
  parameter int RESP_FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             op_sel,
  axis_reduce_endpoint_if.slave  bus
);
  localparam int NUM_STREAMS = 2 ** TID_WIDTH;
  localparam int PTR_W       = $clog2(RESP_FIFO_DEPTH);

`ifdef AXIS_REDUCE_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic {IDLE, ACCUM} stream_state_t;
  typedef enum logic [1:0] {OP_ADD, OP_MAX, OP_MIN, OP_XOR} op_t;

  stream_state_t        state_q [NUM_STREAMS];
  stream_state_t        state_d [NUM_STREAMS];
  logic [ACC_WIDTH-1:0] acc_q   [NUM_STREAMS];
  logic [ACC_WIDTH-1:0] acc_d   [NUM_STREAMS];
  logic [CNT_WIDTH-1:0] cnt_q   [NUM_STREAMS];
  logic [CNT_WIDTH-1:0] cnt_d   [NUM_STREAMS];
  op_t                  op_q    [NUM_STREAMS];
  op_t                  op_d    [NUM_STREAMS];
  logic                 ovf_q   [NUM_STREAMS];
  logic                 ovf_d   [NUM_STREAMS];

  logic [ACC_WIDTH-1:0] operand, acc_cur, acc_new;
  logic [ACC_WIDTH:0]   sum;
  logic [CNT_WIDTH-1:0] cnt_cur, cnt_new;
  op_t                  op_cur;
  logic                 ovf_new;
  logic                 beat_fire, push, pop;

  logic [ACC_WIDTH-1:0] mem_data [RESP_FIFO_DEPTH];
  logic [TID_WIDTH-1:0] mem_tid  [RESP_FIFO_DEPTH];
  logic [CNT_WIDTH-1:0] mem_cnt  [RESP_FIFO_DEPTH];
  logic                 mem_ovf  [RESP_FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [PTR_W:0]       fifo_count;

  // tready depends only on the registered count, so a same-cycle pop never opens a slot
  assign bus.axis_in_tready = !rst && (fifo_count < (PTR_W+1)'(RESP_FIFO_DEPTH));
  assign beat_fire          = bus.axis_in_tvalid && bus.axis_in_tready;
  assign push               = beat_fire && bus.axis_in_tlast;
  assign pop                = bus.resp_valid && bus.resp_ready;

  always_comb begin
    operand = ACC_WIDTH'(bus.axis_in_tdata);
    acc_cur = acc_q[bus.axis_in_tid];
    cnt_cur = cnt_q[bus.axis_in_tid];
    sum     = {1'b0, acc_cur} + {1'b0, operand};
    acc_new = operand;
    cnt_new = CNT_WIDTH'(1);
    op_cur  = op_t'(op_sel);
    ovf_new = 1'b0;
    if (state_q[bus.axis_in_tid] == ACCUM) begin
      op_cur  = op_q[bus.axis_in_tid];
      ovf_new = ovf_q[bus.axis_in_tid];
      cnt_new = (&cnt_cur) ? cnt_cur : cnt_cur + CNT_WIDTH'(1);
      case (op_cur)
        OP_ADD: begin
          if (SAT_EN && sum[ACC_WIDTH]) begin
            acc_new = '1;
            ovf_new = 1'b1;
          end else begin
            acc_new = sum[ACC_WIDTH-1:0];
          end
        end
        OP_MAX:  acc_new = (operand > acc_cur) ? operand : acc_cur;
        OP_MIN:  acc_new = (operand < acc_cur) ? operand : acc_cur;
        default: acc_new = acc_cur ^ operand;
      endcase
    end

    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    ovf_d   = ovf_q;
    if (beat_fire) begin
      state_d[bus.axis_in_tid] = bus.axis_in_tlast ? IDLE : ACCUM;
      acc_d[bus.axis_in_tid]   = acc_new;
      cnt_d[bus.axis_in_tid]   = cnt_new;
      op_d[bus.axis_in_tid]    = op_cur;
      ovf_d[bus.axis_in_tid]   = ovf_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_STREAMS; i++) begin
        state_q[i] <= IDLE;
        acc_q[i]   <= '0;
        cnt_q[i]   <= '0;
        op_q[i]    <= OP_ADD;
        ovf_q[i]   <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (PTR_W+1)'(1);
        2'b01:   fifo_count <= fifo_count - (PTR_W+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= acc_new;
      mem_tid[wr_ptr]  <= bus.axis_in_tid;
      mem_cnt[wr_ptr]  <= cnt_new;
      mem_ovf[wr_ptr]  <= ovf_new;
    end
  end

  // Outputs are forced to zero while empty so the post-reset values are defined
  assign bus.resp_valid    = (fifo_count != '0);
  assign bus.resp_data     = bus.resp_valid ? mem_data[rd_ptr] : '0;
  assign bus.resp_tid      = bus.resp_valid ? mem_tid[rd_ptr]  : '0;
  assign bus.resp_count    = bus.resp_valid ? mem_cnt[rd_ptr]  : '0;
  assign bus.resp_overflow = SAT_EN && bus.resp_valid && mem_ovf[rd_ptr];
endmodule

// File: tb/tb_axis_reduce_endpoint.sv
// Scoreboard bench for axis_reduce_endpoint: directed packets push expected responses,
// monitors pop and compare whenever a response is handed off.
module tb_axis_reduce_endpoint;
  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  tid;
    logic [15:0] count;
    logic        ovf;
  } resp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] op_sel;
  logic [1:0] small_op;

  int total = 0;
  int bad   = 0;

  resp_t exp_q[$];
  resp_t small_q[$];

  axis_reduce_endpoint_if bus ();
  axis_reduce_endpoint_if #(.DATA_WIDTH(8), .ACC_WIDTH(8)) sbus ();

  axis_reduce_endpoint dut (
    .clk    (clk),
    .rst    (rst),
    .op_sel (op_sel),
    .bus    (bus)
  );

  axis_reduce_endpoint #(.DATA_WIDTH(8), .ACC_WIDTH(8)) dut_small (
    .clk    (clk),
    .rst    (rst),
    .op_sel (small_op),
    .bus    (sbus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] tid, input logic [63:0] data,
                               input logic last, input logic [1:0] op);
    bit accepted = 0;
    bus.axis_in_tvalid = 1'b1;
    bus.axis_in_tdata  = data;
    bus.axis_in_tlast  = last;
    bus.axis_in_tid    = tid;
    op_sel             = op;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.axis_in_tready) begin
        accepted = 1;
        break;
      end
    end
    if (!accepted) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: tid %0d data %0d never accepted", tid, data);
    end
    @(posedge clk);
    #1;
    bus.axis_in_tvalid = 1'b0;
    bus.axis_in_tlast  = 1'b0;
  endtask

  task automatic applySmall(input logic [7:0] data, input logic last);
    bit accepted = 0;
    sbus.axis_in_tvalid = 1'b1;
    sbus.axis_in_tdata  = data;
    sbus.axis_in_tlast  = last;
    sbus.axis_in_tid    = 2'd0;
    small_op            = 2'd0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (sbus.axis_in_tready) begin
        accepted = 1;
        break;
      end
    end
    if (!accepted) begin
      total++;
      bad++;
      $display("[TB] FAIL small_accept_timeout: data %0d never accepted", data);
    end
    @(posedge clk);
    #1;
    sbus.axis_in_tvalid = 1'b0;
    sbus.axis_in_tlast  = 1'b0;
  endtask

  task automatic waitDrain();
    for (int c = 0; c < 200 && (exp_q.size() != 0 || small_q.size() != 0); c++)
      @(negedge clk);
  endtask

  // Main monitor: pops on every handoff and checks the head is held while stalled
  initial begin
    resp_t act, held;
    bit    hold_pending = 0;
    forever begin
      @(negedge clk);
      act = {bus.resp_data, bus.resp_tid, bus.resp_count, bus.resp_overflow};
      if (rst) begin
        hold_pending = 0;
      end else begin
        if (hold_pending && bus.resp_valid)
          checkOutput("resp_hold", 128'(act), 128'(held));
        if (bus.resp_valid && bus.resp_ready) begin
          hold_pending = 0;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_resp: got %h expected none", act);
          end else begin
            checkOutput("resp", 128'(act), 128'(exp_q.pop_front()));
          end
        end else if (bus.resp_valid) begin
          held         = act;
          hold_pending = 1;
        end else begin
          hold_pending = 0;
        end
      end
    end
  end

  initial begin
    resp_t act;
    forever begin
      @(negedge clk);
      act = {56'd0, sbus.resp_data, sbus.resp_tid, sbus.resp_count, sbus.resp_overflow};
      if (!rst && sbus.resp_valid && sbus.resp_ready) begin
        if (small_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL small_unexpected_resp: got %h expected none", act);
        end else begin
          checkOutput("small_resp", 128'(act), 128'(small_q.pop_front()));
        end
      end
    end
  end

  initial begin
    rst                 = 1'b1;
    op_sel              = 2'd0;
    small_op            = 2'd0;
    bus.axis_in_tvalid  = 1'b0;
    bus.axis_in_tdata   = '0;
    bus.axis_in_tlast   = 1'b0;
    bus.axis_in_tid     = '0;
    bus.resp_ready      = 1'b1;
    sbus.axis_in_tvalid = 1'b0;
    sbus.axis_in_tdata  = '0;
    sbus.axis_in_tlast  = 1'b0;
    sbus.axis_in_tid    = '0;
    sbus.resp_ready     = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("tready_in_reset", 128'(bus.axis_in_tready), 128'd0);
    checkOutput("reset_outputs",
                128'({bus.resp_valid, bus.resp_data, bus.resp_tid, bus.resp_count, bus.resp_overflow}),
                128'd0);
    checkOutput("small_valid_in_reset", 128'(sbus.resp_valid), 128'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("tready_after_reset", 128'(bus.axis_in_tready), 128'd1);
    @(posedge clk);
    #1;

    $display("[TB] add 1..20 on tid 0");
    for (int i = 1; i <= 20; i++) begin
      if (i == 20) exp_q.push_back('{data: 64'd210, tid: 2'd0, count: 16'd20, ovf: 1'b0});
      applyStimulus(2'd0, 64'(i), i == 20, 2'd0);
    end

    $display("[TB] interleaved max on tid 1 and xor on tid 2");
    applyStimulus(2'd1, 64'd5,    1'b0, 2'd1);
    applyStimulus(2'd2, 64'hF0,   1'b0, 2'd3);
    applyStimulus(2'd1, 64'd9,    1'b0, 2'd1);
    applyStimulus(2'd2, 64'h0F,   1'b0, 2'd3);
    exp_q.push_back('{data: 64'h00, tid: 2'd2, count: 16'd3, ovf: 1'b0});
    applyStimulus(2'd2, 64'hFF,   1'b1, 2'd3);
    exp_q.push_back('{data: 64'd9, tid: 2'd1, count: 16'd3, ovf: 1'b0});
    applyStimulus(2'd1, 64'd3,    1'b1, 2'd1);

    $display("[TB] min on tid 3");
    applyStimulus(2'd3, 64'd9, 1'b0, 2'd2);
    applyStimulus(2'd3, 64'd4, 1'b0, 2'd2);
    exp_q.push_back('{data: 64'd4, tid: 2'd3, count: 16'd3, ovf: 1'b0});
    applyStimulus(2'd3, 64'd6, 1'b1, 2'd2);

    $display("[TB] op_sel switched mid-packet");
    applyStimulus(2'd0, 64'd4, 1'b0, 2'd0);
    exp_q.push_back('{data: 64'd10, tid: 2'd0, count: 16'd2, ovf: 1'b0});
    applyStimulus(2'd0, 64'd6, 1'b1, 2'd2);

    $display("[TB] narrow accumulator add 200+100");
    applySmall(8'd200, 1'b0);
`ifdef AXIS_REDUCE_SAT_EN
    small_q.push_back('{data: 64'd255, tid: 2'd0, count: 16'd2, ovf: 1'b1});
`else
    small_q.push_back('{data: 64'd44, tid: 2'd0, count: 16'd2, ovf: 1'b0});
`endif
    applySmall(8'd100, 1'b1);

    waitDrain();
    @(posedge clk);
    #1;

    $display("[TB] fill response queue with consumer stalled");
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{data: 64'(100 + i), tid: 2'(i), count: 16'd1, ovf: 1'b0});
      applyStimulus(2'(i), 64'(100 + i), 1'b1, 2'd0);
    end
    @(negedge clk);
    checkOutput("tready_full", 128'(bus.axis_in_tready), 128'd0);
    @(posedge clk);
    #1;
    exp_q.push_back('{data: 64'd104, tid: 2'd0, count: 16'd1, ovf: 1'b0});
    bus.resp_ready = 1'b1;
    applyStimulus(2'd0, 64'd104, 1'b1, 2'd0);

    waitDrain();
    @(posedge clk);
    #1;

    $display("[TB] reset in the middle of a packet");
    for (int i = 0; i < 3; i++) applyStimulus(2'd0, 64'd1, 1'b0, 2'd0);
    rst                = 1'b1;
    bus.axis_in_tvalid = 1'b1;
    bus.axis_in_tdata  = 64'd99;
    bus.axis_in_tlast  = 1'b1;
    bus.axis_in_tid    = 2'd0;
    @(negedge clk);
    checkOutput("tready_mid_reset", 128'(bus.axis_in_tready), 128'd0);
    @(posedge clk);
    #1;
    rst                = 1'b0;
    bus.axis_in_tvalid = 1'b0;
    bus.axis_in_tlast  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("valid_after_reset", 128'(bus.resp_valid), 128'd0);
    end
    @(posedge clk);
    #1;
    exp_q.push_back('{data: 64'd7, tid: 2'd0, count: 16'd1, ovf: 1'b0});
    applyStimulus(2'd0, 64'd7, 1'b1, 2'd0);

    waitDrain();
    if (exp_q.size() != 0 || small_q.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout: pending %0d expected 0", exp_q.size() + small_q.size());
    end
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axis_reduce_endpoint.md
# axis_reduce_endpoint

Multi-stream AXI-Stream reduction endpoint attached to one `axis_out` port of the mesh NoC in the user clock domain. Up to 2^TID_WIDTH packets, interleaved flit-by-flit and distinguished by `tid`, are reduced in parallel with a selectable operator. Each packet's result is queued with its TID and beat count when its `tlast` flit is accepted, and the queue is drained through a valid/ready response port. It generalises the single-stream summing adder endpoint.

## Interface
- DATA_WIDTH, 64, input flit width.
- TID_WIDTH, 2, stream ID width; NUM_STREAMS = 2**TID_WIDTH independent accumulators.
- ACC_WIDTH, 64, accumulator/result width; must be >= DATA_WIDTH.
- CNT_WIDTH, 16, per-packet beat counter width.
- RESP_FIFO_DEPTH, 4, response queue entries; power of two, >= 2.
- clk  in  1  user clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- op_sel  in  2  operator: 0 add, 1 unsigned max, 2 unsigned min, 3 xor.
- axis_in_tvalid  in  1  flit valid.
- axis_in_tready  out  1  flit accepted when tvalid && tready.
- axis_in_tdata  in  DATA_WIDTH  operand, zero-extended to ACC_WIDTH.
- axis_in_tlast  in  1  last flit of packet for this tid.
- axis_in_tid  in  TID_WIDTH  stream selector.
- resp_valid  out  1  response head valid.
- resp_ready  in  1  consumer pops head when resp_valid && resp_ready.
- resp_data  out  ACC_WIDTH  reduction result.
- resp_tid  out  TID_WIDTH  stream of result.
- resp_count  out  CNT_WIDTH  beats in packet, saturating at 2^CNT_WIDTH-1.
- resp_overflow  out  1  add result saturated (see Configuration).

## Operation
- Per stream: `active` bit, `acc[ACC_WIDTH]`, `cnt[CNT_WIDTH]`, `op[2]`, `ovf` bit. Stream FSM: IDLE (active=0) -> ACCUM on accepted non-last beat; ACCUM -> IDLE on accepted last beat; IDLE -> IDLE on accepted single-beat packet (first and last).
- First beat of a packet (stream IDLE): acc <= zext(tdata), cnt <= 1, op <= op_sel, ovf <= 0. No identity element is applied.
- Subsequent beats: acc <= acc OP zext(tdata) using the latched op; cnt <= cnt+1 saturating. op_sel changes mid-packet are ignored.
- Add wraps modulo 2^ACC_WIDTH unless saturation is enabled.
- Accepted tlast beat: the final value (including that beat) with tid, count and ovf is written to the response FIFO; the stream returns to IDLE.
- axis_in_tready = !rst && (fifo_count < RESP_FIFO_DEPTH), registered-count based; a same-cycle pop does not raise tready. Non-last beats are also stalled while full (simple, ordering-safe).
- Response FIFO is in order of tlast acceptance, independent of tid.
- Only one input beat per cycle; no inter-stream conflicts.

## Timing
- Reset (rst=1 at a clk edge): all streams IDLE, acc/cnt/ovf cleared, FIFO emptied; resp_valid=0, resp_data=0, resp_tid=0, resp_count=0, resp_overflow=0; axis_in_tready=0 while rst=1, 1 on the first cycle after.
- Reset mid-packet discards all partial accumulations and queued responses; beats presented during reset are not accepted.
- Latency: tlast accepted at edge N -> resp_valid=1 with result from edge N (visible in cycle N+1) when the FIFO was empty.
- Throughput: one beat per cycle sustained; one response pop per cycle.
- Simultaneous push and pop with FIFO full: pop happens, push cannot occur (tready was 0). With FIFO non-full, simultaneous push and pop leave the count unchanged.
- resp_* are stable while resp_valid && !resp_ready.
- FIFO pointers wrap modulo RESP_FIFO_DEPTH.

## Configuration
- AXIS_REDUCE_SAT_EN defined: add (op 0) saturates at 2^ACC_WIDTH-1; ovf becomes sticky for the packet and is reported on resp_overflow.
- AXIS_REDUCE_SAT_EN undefined: add wraps; resp_overflow is tied to 0.
- Max/min/xor are unaffected in both builds.

## Test plan
- tid 0, op add, beats 1..20 with tlast on 20 -> one response: data 210, tid 0, count 20, overflow 0.
- tid 1 max {5,9,3} interleaved beat-by-beat with tid 2 xor {0xF0,0x0F,0xFF}; tid 2 tlast first -> responses in order: (tid 2, 0x00, 3), then (tid 1, 9, 3).
- resp_ready=0, five single-beat packets -> 4 responses queued, tready low after the 4th; raising resp_ready -> responses drain in order and the 5th is accepted.
- ACC_WIDTH=8, add {200,100}: with AXIS_REDUCE_SAT_EN -> 255, overflow 1; without -> 44, overflow 0.
- rst pulsed after 3 beats of tid 0 -> resp_valid stays 0; new packet {7} -> 7, count 1.
- op_sel changes from add to min after the first beat of {4,6} -> 10.
